// File: rtl/par_pkg.sv
// Shared types for the parity-checked serial receiver.
//   par_byte_t  : received byte viewed as four 2-bit fields, x1 = bits[7:6], x4 = bits[1:0]
//   par_state_t : receiver FSM states
//   par_mismatch: parity check helper
package par_pkg;

   typedef struct packed {
      logic [1:0] x1;
      logic [1:0] x2;
      logic [1:0] x3;
      logic [1:0] x4;
   } par_byte_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } par_state_t;

   // True when data plus received parity bit do not give the expected parity.
   function automatic logic par_mismatch(input logic [7:0] d, input logic p, input logic odd);
      return (^d ^ p) != odd;
   endfunction

endpackage

// File: rtl/par_bit_timer.sv
// Bit-period timer for par_rx.
//   clk       : clock
//   rst       : asynchronous active-high reset
//   clr       : restart the count from zero on the next edge
//   half_tick : CLKS_PER_BIT/2 cycles have elapsed since the last clear
//   full_tick : CLKS_PER_BIT cycles have elapsed since the last clear
module par_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic half_tick,
   output logic full_tick
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign half_tick = (cnt == HALF_LAST);
   assign full_tick = (cnt == FULL_LAST);

endmodule

// File: rtl/par_rx.sv
// Serial receiver: start bit, 8 data bits LSB first, parity bit, stop bit.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   rx         : serial line, idle high
//   data       : received byte
//   valid      : data and flags available
//   ready      : consumer takes the byte when valid && ready
//   parity_err : parity mismatch (qualified by valid)
//   all_ones   : &data (qualified by valid)
//   frame_err  : stop bit sampled low (qualified by valid)
//   overrun    : sticky, a frame completed while the previous byte was still unread
module par_rx
   import par_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int ODD_PARITY   = 0
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rx,
   output par_byte_t data,
   output logic      valid,
   input  logic      ready,
   output logic      parity_err,
   output logic      all_ones,
   output logic      frame_err,
   output logic      overrun
);

   localparam logic ODD = (ODD_PARITY != 0);

   par_state_t state, state_n;
   logic [2:0] bit_idx;
   logic [7:0] shift;
   logic       par_bit;
   logic       wait_high;
   logic       timer_clr;
   logic       smp;
   logic       half_tick, full_tick;
   logic       frame_done;
   logic       accept;

   par_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr       (timer_clr),
      .half_tick (half_tick),
      .full_tick (full_tick)
   );

   // Timer is held cleared in IDLE so the START half-period counts from the
   // edge that first sees rx low; every sample point restarts it.
   always_comb begin
      state_n   = state;
      timer_clr = 1'b0;
      smp       = 1'b0;
      case (state)
         IDLE: begin
            timer_clr = 1'b1;
            if (!wait_high && !rx)
               state_n = START;
         end
         START: begin
            if (half_tick) begin
               timer_clr = 1'b1;
               state_n   = rx ? IDLE : DATA;
            end
         end
         DATA: begin
            if (full_tick) begin
               timer_clr = 1'b1;
               smp       = 1'b1;
               if (bit_idx == 3'd7)
                  state_n = PARITY;
            end
         end
         PARITY: begin
            if (full_tick) begin
               timer_clr = 1'b1;
               smp       = 1'b1;
               state_n   = STOP;
            end
         end
         STOP: begin
            if (full_tick) begin
               timer_clr = 1'b1;
               smp       = 1'b1;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign frame_done = smp && (state == STOP);
   assign accept     = valid && ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bit_idx    <= '0;
         shift      <= '0;
         par_bit    <= 1'b0;
         wait_high  <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         all_ones   <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state <= state_n;

         // After a low stop bit the line must return high before a new start.
         if (state == IDLE && rx)
            wait_high <= 1'b0;

         if (smp) begin
            case (state)
               DATA: begin
                  shift   <= {rx, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
               end
               PARITY: par_bit <= rx;
               STOP:   wait_high <= !rx;
               default: ;
            endcase
         end

         // A completing frame may replace the output only if the slot is empty
         // or being drained this cycle; otherwise the old byte is kept.
         if (frame_done) begin
            if (!valid || accept) begin
               data       <= par_byte_t'(shift);
               parity_err <= par_mismatch(shift, par_bit, ODD);
               all_ones   <= &shift;
               frame_err  <= !rx;
               valid      <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (accept) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_par_rx.sv
module tb_par_rx;
   import par_pkg::*;

   localparam int CPB = 4;

   logic      clk;
   logic      rst;
   logic      rx, rx2;
   logic      ready, ready2;
   par_byte_t data, data2;
   logic      valid, valid2;
   logic      parity_err, parity_err2;
   logic      all_ones, all_ones2;
   logic      frame_err, frame_err2;
   logic      overrun, overrun2;

   int n_checks = 0;
   int n_pass   = 0;

   par_rx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .parity_err (parity_err),
      .all_ones   (all_ones),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   par_rx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_odd (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx2),
      .data       (data2),
      .valid      (valid2),
      .ready      (ready2),
      .parity_err (parity_err2),
      .all_ones   (all_ones2),
      .frame_err  (frame_err2),
      .overrun    (overrun2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Drives the first nbits of {stop, parity, data, start} onto the chosen line.
   task automatic send(input logic [7:0] d, input logic p, input logic s, input bit sel, input int nbits);
      logic [10:0] f;
      f = {s, p, d, 1'b0};
      @(posedge clk); #1;
      for (int i = 0; i < nbits; i++) begin
         if (sel) rx2 = f[i]; else rx = f[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      if (nbits == 11) begin
         if (sel) rx2 = 1'b1; else rx = 1'b1;
      end
   endtask

   task automatic wait_valid(input bit sel, input string tag);
      for (int i = 0; i < 200; i++) begin
         if ((sel ? valid2 : valid) === 1'b1) break;
         @(negedge clk);
      end
      check(tag, {7'd0, (sel ? valid2 : valid)}, 8'd1);
   endtask

   task automatic consume(input bit sel);
      @(negedge clk);
      if (sel) ready2 = 1'b1; else ready = 1'b1;
      @(posedge clk); #1;
      if (sel) ready2 = 1'b0; else ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rx = 1'b1; rx2 = 1'b1; ready = 1'b0; ready2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // reset state
      check("rst_data",      data,              8'h00);
      check("rst_valid",     {7'd0, valid},      8'd0);
      check("rst_perr",      {7'd0, parity_err}, 8'd0);
      check("rst_ones",      {7'd0, all_ones},   8'd0);
      check("rst_ferr",      {7'd0, frame_err},  8'd0);
      check("rst_overrun",   {7'd0, overrun},    8'd0);
      check("rst_state",     8'(dut.state),     8'(IDLE));
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // 0xA5, even parity bit 0
      send(8'hA5, 1'b0, 1'b1, 1'b0, 11);
      wait_valid(1'b0, "a5_valid");
      check("a5_data",  data,              8'hA5);
      check("a5_x1",    {6'd0, data.x1},   8'h02);
      check("a5_x4",    {6'd0, data.x4},   8'h01);
      check("a5_perr",  {7'd0, parity_err}, 8'd0);
      check("a5_ones",  {7'd0, all_ones},   8'd0);
      check("a5_ferr",  {7'd0, frame_err},  8'd0);
      repeat (10) @(posedge clk);
      #1;
      check("a5_hold_valid", {7'd0, valid}, 8'd1);
      check("a5_hold_data",  data,          8'hA5);
      consume(1'b0);
      check("a5_drained", {7'd0, valid}, 8'd0);

      // 0xFF with correct and wrong parity
      send(8'hFF, 1'b0, 1'b1, 1'b0, 11);
      wait_valid(1'b0, "ff0_valid");
      check("ff0_data", data,              8'hFF);
      check("ff0_ones", {7'd0, all_ones},   8'd1);
      check("ff0_perr", {7'd0, parity_err}, 8'd0);
      consume(1'b0);
      send(8'hFF, 1'b1, 1'b1, 1'b0, 11);
      wait_valid(1'b0, "ff1_valid");
      check("ff1_perr", {7'd0, parity_err}, 8'd1);
      check("ff1_ones", {7'd0, all_ones},   8'd1);
      consume(1'b0);

      // one-cycle low glitch on idle line
      @(posedge clk); #1;
      rx = 1'b0;
      @(posedge clk); #1;
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("glitch_state", 8'(dut.state), 8'(IDLE));
      check("glitch_valid", {7'd0, valid}, 8'd0);

      // two frames with no consumer
      send(8'h3C, 1'b0, 1'b1, 1'b0, 11);
      wait_valid(1'b0, "3c_valid");
      check("3c_overrun_pre", {7'd0, overrun}, 8'd0);
      send(8'h81, 1'b0, 1'b1, 1'b0, 11);
      repeat (3) @(posedge clk);
      #1;
      check("ovr_data",    data,             8'h3C);
      check("ovr_valid",   {7'd0, valid},    8'd1);
      check("ovr_overrun", {7'd0, overrun},  8'd1);
      consume(1'b0);
      check("ovr_drained", {7'd0, valid},    8'd0);
      check("ovr_sticky",  {7'd0, overrun},  8'd1);

      // stop bit low
      send(8'h12, 1'b0, 1'b0, 1'b0, 11);
      wait_valid(1'b0, "12_valid");
      check("12_data", data,             8'h12);
      check("12_ferr", {7'd0, frame_err}, 8'd1);
      check("12_perr", {7'd0, parity_err}, 8'd0);
      consume(1'b0);

      // odd-parity receiver
      send(8'h01, 1'b0, 1'b1, 1'b1, 11);
      wait_valid(1'b1, "odd01p0_valid");
      check("odd01p0_data", data2,              8'h01);
      check("odd01p0_perr", {7'd0, parity_err2}, 8'd0);
      consume(1'b1);
      send(8'h01, 1'b1, 1'b1, 1'b1, 11);
      wait_valid(1'b1, "odd01p1_valid");
      check("odd01p1_perr", {7'd0, parity_err2}, 8'd1);
      consume(1'b1);

      // reset during data bit 4
      send(8'hF0, 1'b0, 1'b1, 1'b0, 5);
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("mid_state",   8'(dut.state),     8'(DATA));
      check("mid_bit_idx", {5'd0, dut.bit_idx}, 8'd4);
      rst = 1'b1;
      #1;
      check("mid_rst_data",    data,             8'h00);
      check("mid_rst_valid",   {7'd0, valid},    8'd0);
      check("mid_rst_ferr",    {7'd0, frame_err}, 8'd0);
      check("mid_rst_overrun", {7'd0, overrun},  8'd0);
      check("mid_rst_state",   8'(dut.state),   8'(IDLE));
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check("mid_no_valid", {7'd0, valid}, 8'd0);
      send(8'h5A, 1'b0, 1'b1, 1'b0, 11);
      wait_valid(1'b0, "5a_valid");
      check("5a_data",    data,             8'h5A);
      check("5a_perr",    {7'd0, parity_err}, 8'd0);
      check("5a_ferr",    {7'd0, frame_err}, 8'd0);
      check("5a_overrun", {7'd0, overrun},  8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/par_rx.md
PAR_RX -- requirements
Module: par_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, minimum 2.
REQ-002 SHALL have parameter ODD_PARITY, default 0: 0 = even parity (XOR of data and parity bit = 0), 1 = odd parity.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  serial line, idle high.
REQ-006 SHALL have port data  output  8  received byte, typed par_byte_t.
REQ-007 SHALL have port valid  output  1  data and flags available.
REQ-008 SHALL have port ready  input  1  consumer accepts the byte when valid && ready.
REQ-009 SHALL have port parity_err  output  1  received parity mismatched the data; qualified by valid.
REQ-010 SHALL have port all_ones  output  1  reduction-AND of data; qualified by valid.
REQ-011 SHALL have port frame_err  output  1  stop bit sampled 0; qualified by valid.
REQ-012 SHALL have port overrun  output  1  sticky; set when a frame completes while valid is still 1.

Function
REQ-013 SHALL use frame format: start bit 0, 8 data bits LSB first, 1 parity bit, stop bit 1.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL leave IDLE for START on the first cycle rx = 0 is sampled.
REQ-016 SHALL re-sample rx in START at CLKS_PER_BIT/2 cycles; rx = 1 returns to IDLE (glitch rejection); rx = 0 goes to DATA.
REQ-017 SHALL sample each data, parity and stop bit exactly CLKS_PER_BIT cycles after the previous sample.
REQ-018 SHALL count data bits 0..7 with a 3-bit index and go DATA -> PARITY after index 7.
REQ-019 SHALL go PARITY -> STOP after the parity sample, and STOP -> IDLE after the stop sample.
REQ-020 SHALL compute parity_err = (^data ^ parity_bit) != ODD_PARITY.
REQ-021 SHALL compute all_ones = &data.
REQ-022 SHALL, in the cycle after the stop sample, load data, parity_err, all_ones and frame_err, and set valid = 1.
REQ-023 SHALL hold valid, data and all flags stable until the cycle after valid && ready.
REQ-024 SHALL keep the old output byte when a new frame completes while valid = 1, and set overrun = 1.
REQ-025 SHALL load the new frame and hold valid = 1 when completion coincides with valid && ready; overrun SHALL not be set in that case.
REQ-026 SHALL clear overrun only by reset.
REQ-027 SHALL keep receiving while valid = 1 (no back-pressure on rx).
REQ-028 SHALL still produce a frame with frame_err = 1 when the stop bit is 0; the FSM SHALL return to IDLE and wait for rx = 1 before detecting a new start.

Reset
REQ-029 SHALL, on rst = 1, immediately set state = IDLE, data = 0, valid = 0, parity_err = 0, all_ones = 0, frame_err = 0, overrun = 0, and clear all counters.
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame and produce no valid output for it.

Structure
REQ-031 SHALL take from shared package par_pkg: par_byte_t (packed struct of four 2-bit fields x1..x4, x1 = bits[7:6], x4 = bits[1:0]) and the FSM state enum.
REQ-032 SHALL place the bit-period counter in sub-module par_bit_timer (half-period and full-period tick outputs).

Verification
REQ-033 SHALL cover: frame for byte 0xA5 with parity 0, even mode -> data = 0xA5, parity_err = 0, all_ones = 0, frame_err = 0, valid 1 until ready.
REQ-034 SHALL cover: byte 0xFF with parity 0 -> all_ones = 1, parity_err = 0; same byte with parity 1 -> parity_err = 1.
REQ-035 SHALL cover: a 1-cycle low glitch on idle rx -> FSM returns to IDLE and valid stays 0.
REQ-036 SHALL cover: 0x3C then 0x81 sent with ready held 0 -> data stays 0x3C and overrun = 1.
REQ-037 SHALL cover: byte 0x12 with stop bit 0 -> frame_err = 1, valid = 1; ODD_PARITY = 1 with byte 0x01 and parity 0 -> parity_err = 0.
REQ-038 SHALL cover: rst pulse during data bit 4 -> all outputs 0, and the next full frame 0x5A is received correctly.
